// File: rtl/dtlb_pw_arbiter.sv
// dtlb_pw_arbiter
//   Shares a single page walker between NUM_RQ AGU page-walk request ports.
//   Requests are granted round-robin, exactly one walk is in flight at a time,
//   and the walk result is broadcast to every requester tagged with the
//   owner's rqID.
//
// Handshakes:
//   The walk start uses valid/ready. OUT_walk_valid rises in ISSUE and holds
//   with a stable OUT_walk_addr/OUT_walk_rootPPN until IN_walk_ready is
//   sampled high. IN_walk_done is a 1-cycle pulse. It is accepted in WALK, or
//   in ISSUE together with IN_walk_ready (zero-latency walker).
//   Each requester holds IN_req_valid until it sees OUT_pw_busy with its own
//   rqID, then waits for OUT_pw_valid (a 1-cycle broadcast) with that rqID.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   IN_req_valid/addr/rootPPN per-requester request (slice i = requester i)
//   OUT_walk_valid, IN_walk_ready, OUT_walk_addr, OUT_walk_rootPPN  walk start
//   IN_walk_done, IN_walk_res walker completion and result
//   OUT_pw_busy, OUT_pw_rqID  ownership indication (ISSUE/WALK)
//   OUT_pw_valid, OUT_pw_res, OUT_pw_addr  result broadcast (RESP)
//   OUT_walkCnt               completed-walk counter (wraps)
//   OUT_dbg_state             current FSM state, for observation only
module dtlb_pw_arbiter #(
    parameter int NUM_RQ = 3,
    parameter int RQID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RQ-1:0]    IN_req_valid,
    input  logic [NUM_RQ*32-1:0] IN_req_addr,
    input  logic [NUM_RQ*22-1:0] IN_req_rootPPN,
    output logic                 OUT_walk_valid,
    input  logic                 IN_walk_ready,
    output logic [31:0]          OUT_walk_addr,
    output logic [21:0]          OUT_walk_rootPPN,
    input  logic                 IN_walk_done,
    input  logic [27:0]          IN_walk_res,
    output logic                 OUT_pw_busy,
    output logic [RQID_W-1:0]    OUT_pw_rqID,
    output logic                 OUT_pw_valid,
    output logic [27:0]          OUT_pw_res,
    output logic [31:0]          OUT_pw_addr,
    output logic [31:0]          OUT_walkCnt,
    output logic [1:0]           OUT_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WALK  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [RQID_W-1:0] rr_ptr;
    logic [RQID_W-1:0] grant_idx;
    logic [RQID_W-1:0] rr_nxt;
    logic [RQID_W-1:0] grant_q;
    logic              grant_found;
    logic              load_grant;
    logic              load_res;
    logic [31:0]       addr_q;
    logic [21:0]       root_q;
    logic [27:0]       res_q;
    logic [31:0]       walk_cnt;
    logic              walk_valid_q;
    logic              busy_q;
    logic              pw_valid_q;

    // Round-robin scan: first valid index starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_RQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_RQ) idx = idx - NUM_RQ;
            if (!grant_found && IN_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = RQID_W'(idx);
            end
        end
    end

    assign rr_nxt = (grant_idx == RQID_W'(NUM_RQ - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state logic. Requests are only looked at in IDLE, so requesters
    // arriving during a walk keep waiting with valid held.
    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        load_res   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_nxt  = ISSUE;
                    load_grant = 1'b1;
                end
            end
            ISSUE: begin
                // done without ready is illegal and simply ignored here
                if (IN_walk_ready) begin
                    if (IN_walk_done) begin
                        state_nxt = RESP;
                        load_res  = 1'b1;
                    end else begin
                        state_nxt = WALK;
                    end
                end
            end
            WALK: begin
                if (IN_walk_done) begin
                    state_nxt = RESP;
                    load_res  = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs come straight from flops; the control flags are
    // registered from the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            root_q       <= '0;
            res_q        <= '0;
            walk_cnt     <= '0;
            walk_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            pw_valid_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            walk_valid_q <= (state_nxt == ISSUE);
            busy_q       <= (state_nxt == ISSUE) || (state_nxt == WALK);
            pw_valid_q   <= (state_nxt == RESP);
            if (load_grant) begin
                rr_ptr  <= rr_nxt;
                grant_q <= grant_idx;
                addr_q  <= IN_req_addr[32*grant_idx +: 32];
                root_q  <= IN_req_rootPPN[22*grant_idx +: 22];
            end
            if (load_res) res_q <= IN_walk_res;
            if (state_nxt == RESP) walk_cnt <= walk_cnt + 32'd1;
        end
    end

    assign OUT_walk_valid   = walk_valid_q;
    assign OUT_walk_addr    = addr_q;
    assign OUT_walk_rootPPN = root_q;
    assign OUT_pw_busy      = busy_q;
    assign OUT_pw_rqID      = grant_q;
    assign OUT_pw_valid     = pw_valid_q;
    assign OUT_pw_res       = res_q;
    assign OUT_pw_addr      = addr_q;
    assign OUT_walkCnt      = walk_cnt;
    assign OUT_dbg_state    = state;

    a_done_needs_ready: assert property (@(posedge clk) disable iff (!rst)
        !(state == ISSUE && IN_walk_done && !IN_walk_ready));

endmodule

// File: tb/tb_dtlb_pw_arbiter.sv
// Bench for dtlb_pw_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the arbiter (round-robin pick
// by modular scan, walk phases driven by what the walker model did).
module tb_dtlb_pw_arbiter;

  localparam int NUM_RQ = 3;
  localparam int RQID_W = 2;

  typedef enum int {PH_IDLE, PH_ISSUE, PH_WALK, PH_RESP} ph_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_RQ-1:0]    req_valid = '0;
  logic [31:0]          addr_tab[NUM_RQ];
  logic [21:0]          root_tab[NUM_RQ];
  logic [NUM_RQ*32-1:0] req_addr_bus;
  logic [NUM_RQ*22-1:0] req_root_bus;
  logic                 walk_ready = 1'b0;
  logic                 walk_done = 1'b0;
  logic [27:0]          walk_res = '0;

  logic                 out_walk_valid;
  logic [31:0]          out_walk_addr;
  logic [21:0]          out_walk_root;
  logic                 out_busy;
  logic [RQID_W-1:0]    out_rqid;
  logic                 out_pw_valid;
  logic [27:0]          out_pw_res;
  logic [31:0]          out_pw_addr;
  logic [31:0]          out_walk_cnt;
  logic [1:0]           out_dbg_state;

  assign req_addr_bus = {addr_tab[2], addr_tab[1], addr_tab[0]};
  assign req_root_bus = {root_tab[2], root_tab[1], root_tab[0]};

  dtlb_pw_arbiter #(.NUM_RQ(NUM_RQ), .RQID_W(RQID_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_req_valid     (req_valid),
    .IN_req_addr      (req_addr_bus),
    .IN_req_rootPPN   (req_root_bus),
    .OUT_walk_valid   (out_walk_valid),
    .IN_walk_ready    (walk_ready),
    .OUT_walk_addr    (out_walk_addr),
    .OUT_walk_rootPPN (out_walk_root),
    .IN_walk_done     (walk_done),
    .IN_walk_res      (walk_res),
    .OUT_pw_busy      (out_busy),
    .OUT_pw_rqID      (out_rqid),
    .OUT_pw_valid     (out_pw_valid),
    .OUT_pw_res       (out_pw_res),
    .OUT_pw_addr      (out_pw_addr),
    .OUT_walkCnt      (out_walk_cnt),
    .OUT_dbg_state    (out_dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [27:0] exp_q[$];
  int resp_log[$];

  ph_t ph = PH_IDLE;
  int owner = 0;
  int m_rr = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] own_addr = '0;
  logic [21:0] own_root = '0;
  int cyc = 0;
  int grant_cyc = 0;
  int last_lat = 0;
  int resp_count = 0;
  int issue_cnt = 0;

  // walker / requester behaviour knobs
  int ready_wait = 0;
  int walk_lat = 0;
  bit zero_lat = 1'b0;
  int cfg_ready_wait = 0;
  int cfg_walk_lat = 0;
  bit cfg_zero = 1'b0;
  bit rand_walker = 1'b0;
  bit rand_req = 1'b0;
  bit hold_all = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // First requesting index at or after ptr, modulo NUM_RQ.
  function automatic int rr_pick(input logic [NUM_RQ-1:0] m, input int ptr);
    for (int k = 0; k < NUM_RQ; k++) begin
      if (m[(ptr + k) % NUM_RQ]) return (ptr + k) % NUM_RQ;
    end
    return -1;
  endfunction

  task automatic reset_model();
    ph = PH_IDLE;
    m_rr = 0;
    m_cnt = '0;
    owner = 0;
    exp_q.delete();
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic do_reset_async();
    #2;
    rst = 1'b0;
    walk_ready = 1'b0;
    walk_done = 1'b0;
    #1;
    check("rst_walk_valid", out_walk_valid, 0);
    check("rst_busy", out_busy, 0);
    check("rst_pw_valid", out_pw_valid, 0);
    check("rst_rqid", out_rqid, 0);
    check("rst_walk_addr", out_walk_addr, 0);
    check("rst_walk_root", out_walk_root, 0);
    check("rst_pw_res", out_pw_res, 0);
    check("rst_pw_addr", out_pw_addr, 0);
    check("rst_walk_cnt", out_walk_cnt, 0);
    check("rst_state", out_dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_model();
  endtask

  // One clock: advance the model with what was driven, compare, then drive.
  task automatic cycle();
    bit granted;
    @(negedge clk);
    cyc++;
    granted = 1'b0;
    case (ph)
      PH_IDLE: begin
        if (req_valid != '0) begin
          owner = rr_pick(req_valid, m_rr);
          m_rr = (owner + 1) % NUM_RQ;
          own_addr = addr_tab[owner];
          own_root = root_tab[owner];
          grant_cyc = cyc;
          ph = PH_ISSUE;
          granted = 1'b1;
          if (rand_walker) begin
            ready_wait = $urandom_range(0, 3);
            walk_lat = $urandom_range(0, 4);
            zero_lat = ($urandom_range(0, 3) == 0);
          end else begin
            ready_wait = cfg_ready_wait;
            walk_lat = cfg_walk_lat;
            zero_lat = cfg_zero;
          end
        end
      end
      PH_ISSUE: if (walk_ready) ph = walk_done ? PH_RESP : PH_WALK;
      PH_WALK:  if (walk_done) ph = PH_RESP;
      default:  ph = PH_IDLE;
    endcase
    if (ph == PH_RESP) begin
      m_cnt = m_cnt + 32'd1;
      last_lat = cyc - grant_cyc;
      resp_count++;
      resp_log.push_back(int'(out_rqid));
    end

    check("walk_valid", out_walk_valid, ph == PH_ISSUE);
    check("busy", out_busy, (ph == PH_ISSUE) || (ph == PH_WALK));
    check("pw_valid", out_pw_valid, ph == PH_RESP);
    check("walk_cnt", out_walk_cnt, m_cnt);
    if (ph != PH_IDLE) check("rqid", out_rqid, owner);
    if (ph == PH_ISSUE) begin
      check("walk_addr", out_walk_addr, own_addr);
      check("walk_root", out_walk_root, own_root);
      if (out_walk_valid) issue_cnt++;
    end
    if (ph == PH_RESP) begin
      check("pw_addr", out_pw_addr, own_addr);
      check("res_queued", exp_q.size(), 1);
      if (exp_q.size() > 0) check("pw_res", out_pw_res, exp_q.pop_front());
    end

    // requester drops its valid once it sees busy with its own rqID
    if (granted && !hold_all) req_valid[owner] = 1'b0;
    walk_ready = 1'b0;
    walk_done = 1'b0;
    if (ph == PH_ISSUE) begin
      if (ready_wait == 0) begin
        walk_ready = 1'b1;
        if (zero_lat) begin
          walk_done = 1'b1;
          walk_res = 28'($urandom);
          exp_q.push_back(walk_res);
        end
      end else begin
        ready_wait--;
      end
    end else if (ph == PH_WALK) begin
      if (walk_lat == 0) begin
        walk_done = 1'b1;
        walk_res = 28'($urandom);
        exp_q.push_back(walk_res);
      end else begin
        walk_lat--;
      end
    end
    if (rand_req) begin
      for (int i = 0; i < NUM_RQ; i++) begin
        if (!req_valid[i]) begin
          addr_tab[i] = $urandom;
          root_tab[i] = 22'($urandom);
          if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_walks(input int n, input int bound);
    int start;
    int k;
    start = resp_count;
    k = 0;
    while (resp_count < start + n && k < bound) begin
      cycle();
      k++;
    end
    check("walks_done", resp_count - start, n);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int exp_order[4];
    int k;
    exp_order = '{0, 1, 2, 0};
    for (int i = 0; i < NUM_RQ; i++) begin
      addr_tab[i] = 32'h1000_0000 * (i + 1);
      root_tab[i] = 22'(i + 7);
    end

    // reset values
    do_reset_async();

    // single request from requester 1
    addr_tab[1] = 32'h8000_1234;
    root_tab[1] = 22'h12345;
    cfg_ready_wait = 0; cfg_walk_lat = 2; cfg_zero = 1'b0;
    resp_log.delete();
    req_valid = 3'b010;
    wait_walks(1, 30);
    check("t1_rqid", resp_log[0], 1);
    check("t1_latency", last_lat, 4);
    check("t1_cnt", out_walk_cnt, 1);
    repeat (2) cycle();

    // round robin with all requesters held; also re-checks reset
    do_reset_async();
    resp_log.delete();
    cfg_walk_lat = 1;
    hold_all = 1'b1;
    req_valid = 3'b111;
    wait_walks(4, 60);
    hold_all = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) check("rr_order", resp_log[i], exp_order[i]);
    repeat (2) cycle();

    // zero-latency walker
    cfg_zero = 1'b1;
    req_valid = 3'b001;
    wait_walks(1, 20);
    check("zl_latency", last_lat, 1);
    cfg_zero = 1'b0;
    repeat (2) cycle();

    // walker backpressure with a competing request pending
    cfg_ready_wait = 10;
    issue_cnt = 0;
    resp_log.delete();
    req_valid = 3'b011;
    wait_walks(1, 40);
    check("bp_issue_cycles", issue_cnt, 11);
    cfg_ready_wait = 0;
    wait_walks(1, 20);
    check("bp_order0", resp_log[0], 1);
    check("bp_order1", resp_log[1], 0);
    repeat (2) cycle();

    // async reset in the middle of a walk; rr pointer must restart at 0
    cfg_walk_lat = 20;
    req_valid = 3'b010;
    k = 0;
    while (ph != PH_WALK && k < 20) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    check("t5_in_walk", out_busy, 1);
    req_valid = 3'b101;
    cfg_walk_lat = 1;
    do_reset_async();
    resp_log.delete();
    wait_walks(2, 40);
    check("rst_regrant0", resp_log[0], 0);
    check("rst_regrant1", resp_log[1], 2);
    repeat (2) cycle();

    // counter wrap
    force dut.walk_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.walk_cnt;
    m_cnt = 32'hFFFF_FFFF;
    req_valid = 3'b100;
    wait_walks(1, 20);
    check("cnt_wrap", out_walk_cnt, 0);
    repeat (2) cycle();

    // random traffic
    rand_walker = 1'b1;
    rand_req = 1'b1;
    repeat (400) cycle();
    rand_req = 1'b0;
    k = 0;
    while ((req_valid != '0 || ph != PH_IDLE) && k < 300) begin
      cycle();
      k++;
    end
    check("drain_pending", req_valid, 0);
    check("drain_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dtlb_pw_arbiter.md
Name: dtlb_pw_arbiter

Overview:
- Sits between the NUM_RQ load/store AGU page-walk request ports and the single shared page walker.
- Each AGU holds its request valid until it sees busy with its own rqID, then waits for a broadcast result.
- This block grants requesters round-robin, runs exactly one walk at a time, and broadcasts the result to all requesters tagged with the winner's rqID.

Parameters:
- NUM_RQ, 3, number of requesting AGUs; requester i has rqID i.
- RQID_W, 2, width of rqID fields; must satisfy 2^RQID_W >= NUM_RQ.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- IN_req_valid  in  NUM_RQ  per-requester page-walk request valid
- IN_req_addr  in  NUM_RQ*32  per-requester virtual address; slice i = bits [32*i+31:32*i]
- IN_req_rootPPN  in  NUM_RQ*22  per-requester satp root PPN
- OUT_walk_valid  out  1  walk start to walker
- IN_walk_ready  in  1  walker accepts start
- OUT_walk_addr  out  32  latched VA
- OUT_walk_rootPPN  out  22  latched root PPN
- IN_walk_done  in  1  walker finished (1-cycle pulse)
- IN_walk_res  in  28  {ppn[21:0], rwx[2:0], user, pageFault, accessFault}
- OUT_pw_busy  out  1  a request is owned (ISSUE/WALK)
- OUT_pw_rqID  out  RQID_W  owner of current walk / result
- OUT_pw_valid  out  1  result broadcast, 1-cycle pulse
- OUT_pw_res  out  28  broadcast result, same packing as IN_walk_res
- OUT_pw_addr  out  32  VA of the broadcast result
- OUT_walkCnt  out  32  completed-walk counter

Behaviour:
- States: IDLE, ISSUE, WALK, RESP.
- Reset (rst=0, async):
  - state=IDLE, rrPtr=0, OUT_walkCnt=0.
  - All valids/busy=0; OUT_pw_rqID=0; data outputs 0.
  - Reset mid-walk abandons the walk silently; the walker shares the same reset.
- IDLE:
  - If any IN_req_valid is set, grant the first valid index scanning rrPtr, rrPtr+1, …, wrapping mod NUM_RQ.
  - Latch that requester's addr/rootPPN and rqID=grant; set rrPtr<=(grant+1) mod NUM_RQ; go to ISSUE.
  - No request: stay in IDLE, outputs idle.
- ISSUE:
  - OUT_walk_valid=1 with latched addr/rootPPN.
  - OUT_pw_busy=1 and OUT_pw_rqID=grant, starting the cycle after the grant.
  - IN_walk_ready=1 → WALK.
  - IN_walk_ready=1 and IN_walk_done=1 in the same cycle (zero-latency walker) → latch result, go directly to RESP.
  - IN_walk_done without ready is a protocol error; flag it with a simulation assertion and ignore it.
- WALK:
  - OUT_walk_valid=0, OUT_pw_busy=1.
  - IN_walk_done → latch IN_walk_res → RESP.
- RESP (exactly one cycle):
  - OUT_pw_valid=1, OUT_pw_busy=0, OUT_pw_rqID=grant, OUT_pw_res/OUT_pw_addr = latched values.
  - OUT_walkCnt+=1 (wraps at 2^32).
  - Next state IDLE. Arbitration resumes in IDLE, so back-to-back walks have a 1-cycle IDLE gap.
- Request handling:
  - Requests arriving in ISSUE/WALK/RESP are not sampled; requesters keep valid asserted and are serviced later.
  - Deasserting a request after it is granted does not cancel the walk.
- Output timing: all outputs are registered, none combinational from inputs.
- Fairness: with all NUM_RQ requesting continuously, grants rotate 0,1,2,0,…; no requester waits more than NUM_RQ-1 walks.

Test Plan:
- Reset then single request: req_valid=3'b010, addr=0x80001234, root=0x12345; walker ready next cycle, done 3 cycles later → OUT_walk_addr=0x80001234; busy=1, rqID=1 during ISSUE/WALK; one-cycle pw_valid with rqID=1 and result echoed; walkCnt=1.
- Round-robin: req_valid=3'b111 held, walker 2-cycle latency → grant order 0,1,2,0; rqID sequence matches; exactly one pw_valid per walk.
- Zero-latency walker: ready and done together in first ISSUE cycle → RESP on the next cycle, no WALK state, total grant-to-pw_valid of 2 cycles.
- Walker backpressure: ready held low 10 cycles → OUT_walk_valid and addr stable for all 10 cycles, busy stays 1, no second grant.
- Async reset asserted mid-WALK → all outputs 0 immediately without a clock edge; after release, pending req_valid=3'b100 is granted with rrPtr=0 scan (grant 2).
- Counter wrap: preload scenario of 2^32-1 walks (force) then one walk → OUT_walkCnt=0.
